// File: rtl/reg_port_arb_if.sv
// Signal bundle between the register-port arbiter, the core writeback/read stage,
// the debug requester and the register file instance.
interface reg_port_arb_if #(
    parameter int p_WORD_LEN     = 16,
    parameter int p_REG_ADDR_LEN = 3
);
    // Core writeback and read-port-1 address
    logic                      i_wb_en;
    logic [p_REG_ADDR_LEN-1:0] i_wb_tgt;
    logic [p_WORD_LEN-1:0]     i_wb_data;
    logic [p_REG_ADDR_LEN-1:0] i_core_src1;
    logic                      o_core_stall;

    // Debug / loader requester, 4-phase req/ack
    logic                      i_dbg_req;
    logic                      i_dbg_we;
    logic [p_REG_ADDR_LEN-1:0] i_dbg_addr;
    logic [p_WORD_LEN-1:0]     i_dbg_wdata;
    logic                      o_dbg_ack;
    logic [p_WORD_LEN-1:0]     o_dbg_rdata;

    // Register-file write port and read port 1
    logic                      o_rf_wr_en;
    logic [p_REG_ADDR_LEN-1:0] o_rf_tgt;
    logic [p_WORD_LEN-1:0]     o_rf_tgt_data;
    logic [p_REG_ADDR_LEN-1:0] o_rf_src1;
    logic [p_WORD_LEN-1:0]     i_rf_src1_data;

    modport slave (
        input  i_wb_en, i_wb_tgt, i_wb_data, i_core_src1,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        input  i_rf_src1_data,
        output o_core_stall, o_dbg_ack, o_dbg_rdata,
        output o_rf_wr_en, o_rf_tgt, o_rf_tgt_data, o_rf_src1
    );

    modport master (
        output i_wb_en, i_wb_tgt, i_wb_data, i_core_src1,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        output i_rf_src1_data,
        input  o_core_stall, o_dbg_ack, o_dbg_rdata,
        input  o_rf_wr_en, o_rf_tgt, o_rf_tgt_data, o_rf_src1
    );
endinterface

// File: rtl/reg_port_arb.sv
// Shares the register-file write port (and, with REG_PORT_ARB_DBG_RD_EN defined, read
// port 1) between core writeback and a debug requester, forcing debug through after starvation.
module reg_port_arb #(
    parameter int p_WORD_LEN     = 16,
    parameter int p_REG_ADDR_LEN = 3,
    parameter int p_STARVE_LIMIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    reg_port_arb_if.slave bus
);
    localparam int CNT_W = (p_STARVE_LIMIT < 1) ? 1 : $clog2(p_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(p_STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic             ack_reg;

`ifdef REG_PORT_ARB_DBG_RD_EN
    logic [p_WORD_LEN-1:0] rdata_reg;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^bus.i_rf_src1_data;
`endif

    // Debug wins immediately when the core is not writing, otherwise only once starved.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            ack_reg        <= 1'b0;
`ifdef REG_PORT_ARB_DBG_RD_EN
            rdata_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_dbg_req) begin
                        if (!bus.i_wb_en || starve_cnt_reg == STARVE_MAX) begin
                            state_reg      <= GRANT;
                            starve_cnt_reg <= '0;
                        end else begin
                            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt_reg <= '0;
                    end
                end
                GRANT: begin
                    state_reg <= ACK;
                    ack_reg   <= 1'b1;
`ifdef REG_PORT_ARB_DBG_RD_EN
                    if (!bus.i_dbg_we) begin
                        rdata_reg <= bus.i_rf_src1_data;
                    end
`endif
                end
                ACK: begin
                    if (!bus.i_dbg_req) begin
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    // The register-file side follows the core except during the single GRANT cycle.
    always_comb begin
        bus.o_rf_wr_en    = bus.i_wb_en;
        bus.o_rf_tgt      = bus.i_wb_tgt;
        bus.o_rf_tgt_data = bus.i_wb_data;
        bus.o_rf_src1     = bus.i_core_src1;
        if (state_reg == GRANT) begin
            bus.o_rf_wr_en    = bus.i_dbg_we;
            bus.o_rf_tgt      = bus.i_dbg_addr;
            bus.o_rf_tgt_data = bus.i_dbg_wdata;
`ifdef REG_PORT_ARB_DBG_RD_EN
            bus.o_rf_src1     = bus.i_dbg_addr;
`endif
        end
    end

    assign bus.o_core_stall = (state_reg == GRANT);
    assign bus.o_dbg_ack    = ack_reg;

`ifdef REG_PORT_ARB_DBG_RD_EN
    assign bus.o_dbg_rdata = rdata_reg;
`else
    assign bus.o_dbg_rdata = '0;
`endif

endmodule
